// File: rtl/dpll_pkg.sv
// Shared types and helpers for the DPLL digitally controlled oscillator.
// Shift direction encoding and pending-sign to period-length mapping.
package dpll_pkg;

  typedef enum logic [1:0] {
    SHIFT_NONE = 2'd0,
    SHIFT_ADV  = 2'd1,
    SHIFT_RET  = 2'd2
  } shift_dir_e;

  function automatic shift_dir_e sign_dir(input int value);
    if (value > 0) return SHIFT_ADV;
    if (value < 0) return SHIFT_RET;
    return SHIFT_NONE;
  endfunction

  function automatic int period_len(
    input shift_dir_e dir,
    input int         divide
  );
    case (dir)
      SHIFT_ADV: return divide - 1;
      SHIFT_RET: return divide + 1;
      default:   return divide;
    endcase
  endfunction

endpackage

// File: rtl/shift_accumulator.sv
// Saturating signed up/down counter of outstanding phase corrections.
// Consumption is applied before new requests; overflow is dropped.
module shift_accumulator #(
  parameter int PENDING_MAX = 7
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   inc_i,
  input  logic                                   dec_i,
  input  logic                                   consume_i,
  input  logic                                   consumeDir_i,
  output logic signed [$clog2(PENDING_MAX+1):0] value_o
);

  localparam int PW = $clog2(PENDING_MAX + 1) + 1;

  logic signed [PW-1:0] r_value;
  logic signed [PW-1:0] w_next;
  int                   w_sum;

  // next value: consume one step toward zero, add requests, then clamp
  always_comb begin
    w_sum = int'(r_value);
    if (consume_i) begin
      w_sum = consumeDir_i ? w_sum - 1 : w_sum + 1;
    end
    if (inc_i) w_sum = w_sum + 1;
    if (dec_i) w_sum = w_sum - 1;
    if (w_sum > PENDING_MAX) begin
      w_next = PW'(PENDING_MAX);
    end else if (w_sum < -PENDING_MAX) begin
      w_next = PW'(-PENDING_MAX);
    end else begin
      w_next = PW'(w_sum);
    end
  end

  // accumulator register
  always_ff @(posedge clk_i) begin
    if (reset_i) r_value <= '0;
    else         r_value <= w_next;
  end

  assign value_o = r_value;

endmodule

// File: rtl/phase_shift_dco.sv
// DPLL oscillator: system clock divider whose period is trimmed by
// one cycle per period from the pending shift accumulator.
module phase_shift_dco
  import dpll_pkg::*;
#(
  parameter int DIVIDE      = 16,
  parameter int PENDING_MAX = 7
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   positiveShift_i,
  input  logic                                   negativeShift_i,
  output logic                                   recoveredClock_o,
  output logic                                   tick_o,
  output logic [$clog2(DIVIDE+1)-1:0]            phase_o,
  output logic signed [$clog2(PENDING_MAX+1):0] pending_o
);

  localparam int CW = $clog2(DIVIDE + 1);
  localparam int PW = $clog2(PENDING_MAX + 1) + 1;

  logic [CW-1:0]        r_count;
  logic [CW-1:0]        r_len;
  logic                 r_tick;
  logic                 r_clk;
  logic [CW-1:0]        w_count_next;
  logic                 w_wrap;
  logic                 w_consume;
  logic                 w_consume_adv;
  shift_dir_e           w_dir;
  logic signed [PW-1:0] w_pending;

  // wrap detection, next count and direction of the pending correction
  always_comb begin
    w_wrap        = (r_count == r_len - CW'(1));
    w_count_next  = w_wrap ? '0 : r_count + CW'(1);
    w_dir         = sign_dir(int'(w_pending));
    w_consume     = w_wrap && (w_dir != SHIFT_NONE);
    w_consume_adv = (w_dir == SHIFT_ADV);
  end

  // divider, period length latch and registered outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_count <= '0;
      r_len   <= CW'(DIVIDE);
      r_tick  <= 1'b0;
      r_clk   <= 1'b0;
    end else begin
      r_count <= w_count_next;
      if (w_wrap) r_len <= CW'(period_len(w_dir, DIVIDE));
      r_tick  <= w_wrap;
      r_clk   <= (w_count_next < CW'(DIVIDE / 2));
    end
  end

  shift_accumulator #(
    .PENDING_MAX (PENDING_MAX)
  ) u_acc (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .inc_i        (positiveShift_i),
    .dec_i        (negativeShift_i),
    .consume_i    (w_consume),
    .consumeDir_i (w_consume_adv),
    .value_o      (w_pending)
  );

  assign recoveredClock_o = r_clk;
  assign tick_o           = r_tick;
  assign phase_o          = r_count;
  assign pending_o        = w_pending;

endmodule

// File: tb/tb_phase_shift_dco.sv
// Bench for phase_shift_dco: directed and random shift pulses checked
// every cycle against a period-timeline reference model.
module tb_phase_shift_dco;

  localparam int D  = 16;
  localparam int PM = 7;

  logic              clk = 1'b0;
  logic              reset_i = 1'b1;
  logic              positiveShift_i = 1'b0;
  logic              negativeShift_i = 1'b0;
  logic              recoveredClock_o;
  logic              tick_o;
  logic [4:0]        phase_o;
  logic signed [3:0] pending_o;

  int checks = 0;
  int passed = 0;

  int n         = 0;
  int start     = 0;
  int next_wrap = D;
  int pend      = 0;
  int plen      = D;
  logic m_tick  = 1'b0;
  logic m_clk   = 1'b0;

  always #5 clk = ~clk;

  phase_shift_dco #(
    .DIVIDE      (D),
    .PENDING_MAX (PM)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .positiveShift_i  (positiveShift_i),
    .negativeShift_i  (negativeShift_i),
    .recoveredClock_o (recoveredClock_o),
    .tick_o           (tick_o),
    .phase_o          (phase_o),
    .pending_o        (pending_o)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cycle %0d: got %0d expected %0d", tag, n, obs, exp);
  endtask

  task automatic step(input logic rst, input logic pos, input logic neg);
    logic w;
    @(negedge clk);
    reset_i         = rst;
    positiveShift_i = pos;
    negativeShift_i = neg;
    @(posedge clk);
    n++;
    if (rst) begin
      pend      = 0;
      start     = n;
      next_wrap = n + D;
      m_tick    = 1'b0;
      m_clk     = 1'b0;
    end else begin
      w = (n == next_wrap);
      if (w) begin
        plen = (pend > 0) ? D - 1 : (pend < 0) ? D + 1 : D;
        if (pend > 0) pend--;
        else if (pend < 0) pend++;
        start     = n;
        next_wrap = n + plen;
      end
      pend = pend + int'(pos) - int'(neg);
      if (pend > PM) pend = PM;
      if (pend < -PM) pend = -PM;
      m_tick = w;
      m_clk  = (n - start) < D / 2;
    end
    #1;
    chk("tick", int'(tick_o), int'(m_tick));
    chk("rclk", int'(recoveredClock_o), int'(m_clk));
    chk("phase", int'(phase_o), n - start);
    chk("pending", int'(pending_o), pend);
  endtask

  initial begin
    step(1, 0, 0);
    step(1, 0, 0);
    // free run
    for (int i = 0; i < 40; i++) step(0, 0, 0);
    // single advance at cycle 3
    step(1, 0, 0);
    for (int i = 1; i <= 40; i++) step(0, i == 3, 0);
    // single retard mid-period
    step(1, 0, 0);
    for (int i = 1; i <= 40; i++) step(0, 0, i == 7);
    // both together cancel
    step(1, 0, 0);
    for (int i = 1; i <= 40; i++) begin
      step(0, (i % 4 == 0) && i <= 20, (i % 4 == 0) && i <= 20);
    end
    // saturation from 10 consecutive advances
    step(1, 0, 0);
    for (int i = 1; i <= 140; i++) step(0, i <= 10, 0);
    // advance on the wrap edge while one is pending
    step(1, 0, 0);
    for (int i = 1; i <= 40; i++) begin
      step(0, (i == 3) || (i > 3 && i < 20 && n + 1 == next_wrap), 0);
    end
    // reset at count 9 with pending -3
    step(1, 0, 0);
    for (int i = 1; i <= 9; i++) step(0, 0, i <= 3);
    chk("pend_m3", int'(pending_o), -3);
    chk("count9", int'(phase_o), 9);
    step(1, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0);
    // random pulses with occasional reset
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 5) == 0);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
